// File: rtl/iopad_share_arbiter.sv
// Round-robin owner arbitration for one shared OBUFT/IBUF pad, with a forced
// high-Z turnaround between successive owners.
//
// state | meaning
// IDLE  | pad high-Z, no owner; picks next requester round-robin from ptr
// OWN   | grant held by owner, pad driven from its drv_data bit
// TURN  | pad forced high-Z, counting down the turnaround
module iopad_share_arbiter #(
  parameter int N_REQ      = 4,
  parameter int TURNAROUND = 2,
  parameter int MAX_HOLD   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] drv_data,
  output logic [N_REQ-1:0] grant,
  output logic             pad_i,
  output logic             pad_t,
  input  logic             pad_o,
  output logic             rd_data,
  output logic             busy
);

  localparam int PW = $clog2(N_REQ);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [TW-1:0] TURN_INIT = TW'(TURNAROUND - 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [HW-1:0] hold;
  logic [TW-1:0] turn;

  logic          hi_vld;
  logic          lo_vld;
  logic [PW-1:0] hi_idx;
  logic [PW-1:0] lo_idx;
  logic [PW-1:0] pick_idx;
  logic          others_req;
  logic          release_own;

  // Lowest set index at or above ptr wins; otherwise wrap to the lowest set index.
  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req[j]) begin
        lo_vld = 1'b1;
        lo_idx = PW'(j);
        if (PW'(j) >= ptr) begin
          hi_vld = 1'b1;
          hi_idx = PW'(j);
        end
      end
    end
    pick_idx = hi_vld ? hi_idx : lo_idx;
  end

  assign others_req  = |(req & ~grant);
  assign release_own = !req[owner] ||
                       ((MAX_HOLD != 0) && (hold == HOLD_LAST) && others_req);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant   <= '0;
      pad_t   <= 1'b1;
      pad_i   <= 1'b0;
      rd_data <= 1'b0;
      ptr     <= '0;
      owner   <= '0;
      hold    <= '0;
      turn    <= '0;
    end else begin
      rd_data <= pad_o;
      case (state)
        IDLE: begin
          if (lo_vld) begin
            grant <= N_REQ'(1) << pick_idx;
            owner <= pick_idx;
            hold  <= '0;
            state <= OWN;
          end
        end
        OWN: begin
          if (release_own) begin
            grant <= '0;
            pad_t <= 1'b1;
            pad_i <= 1'b0;
            ptr   <= (owner == PTR_LAST) ? '0 : owner + 1'b1;
            turn  <= TURN_INIT;
            state <= TURN;
          end else begin
            pad_t <= 1'b0;
            pad_i <= drv_data[owner];
            if ((MAX_HOLD != 0) && (hold != HOLD_MAX)) hold <= hold + 1'b1;
          end
        end
        TURN: begin
          if (turn == '0) state <= IDLE;
          else            turn  <= turn - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iopad_share_arbiter.sv
// Directed bench for iopad_share_arbiter (N_REQ=4, TURNAROUND=2, MAX_HOLD=4)
// with a simple pad model feeding pad_o.
module tb_iopad_share_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] drv_data;
  logic [3:0] grant;
  logic       pad_i;
  logic       pad_t;
  logic       pad_o;
  logic       rd_data;
  logic       busy;
  logic       ext_drv;

  int n_chk = 0;
  int n_err = 0;

  iopad_share_arbiter #(.N_REQ(4), .TURNAROUND(2), .MAX_HOLD(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .drv_data (drv_data),
    .grant    (grant),
    .pad_i    (pad_i),
    .pad_t    (pad_t),
    .pad_o    (pad_o),
    .rd_data  (rd_data),
    .busy     (busy)
  );

  // Pad model: the external device drives only while our OBUFT is high-Z.
  assign pad_o = pad_t ? ext_drv : pad_i;

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] rr_exp [5];
    int         n;

    rr_exp[0] = 4'b0001;
    rr_exp[1] = 4'b0010;
    rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000;
    rr_exp[4] = 4'b0001;

    rst_n    = 1'b0;
    req      = 4'b0000;
    drv_data = 4'b0000;
    ext_drv  = 1'b0;
    step();
    step();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_pad_t", 32'(pad_t), 32'h1);
    chk("rst_pad_i", 32'(pad_i), 32'h0);
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;

    // Single owner, drv_data toggling 1,0,1
    req = 4'b0001;
    step();
    chk("single_grant_c1", 32'(grant), 32'h1);
    chk("single_pad_t_c1", 32'(pad_t), 32'h1);
    chk("single_busy_c1", 32'(busy), 32'h1);
    drv_data = 4'b0001;
    step();
    chk("single_pad_t_c2", 32'(pad_t), 32'h0);
    chk("single_pad_i_c2", 32'(pad_i), 32'h1);
    drv_data = 4'b0000;
    step();
    chk("single_pad_i_c3", 32'(pad_i), 32'h0);
    chk("single_rd_data_c3", 32'(rd_data), 32'h1);
    drv_data = 4'b0001;
    step();
    chk("single_pad_i_c4", 32'(pad_i), 32'h1);
    chk("single_rd_data_c4", 32'(rd_data), 32'h0);
    req = 4'b0000;
    step();
    chk("single_drop_grant", 32'(grant), 32'h0);
    chk("single_drop_pad_t", 32'(pad_t), 32'h1);
    chk("single_drop_pad_i", 32'(pad_i), 32'h0);
    chk("single_drop_busy", 32'(busy), 32'h1);
    step();
    step();
    chk("single_idle_busy", 32'(busy), 32'h0);

    // Turnaround: req0 owns, req2 waits, req0 drops (ptr is 1 here)
    req = 4'b0001;
    step();
    chk("turn_grant0", 32'(grant), 32'h1);
    req = 4'b0101;
    step();
    chk("turn_grant0_held", 32'(grant), 32'h1);
    chk("turn_pad_t_driven", 32'(pad_t), 32'h0);
    req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("turn_gap_grant_%0d", c), 32'(grant), 32'h0);
      chk($sformatf("turn_gap_pad_t_%0d", c), 32'(pad_t), 32'h1);
    end
    step();
    chk("turn_grant2", 32'(grant), 32'h4);
    chk("turn_grant2_pad_t", 32'(pad_t), 32'h1);
    step();
    chk("turn_grant2_driven", 32'(pad_t), 32'h0);
    req = 4'b0000;
    step();
    step();
    step();
    chk("turn_idle_busy", 32'(busy), 32'h0);

    // Preemption: req0 alone (ptr is 3), req3 joins one cycle later
    req = 4'b0001;
    step();
    chk("pre_grant0_c0", 32'(grant), 32'h1);
    req = 4'b1001;
    step();
    step();
    step();
    chk("pre_grant0_c3", 32'(grant), 32'h1);
    step();
    chk("pre_release_grant", 32'(grant), 32'h0);
    chk("pre_release_pad_t", 32'(pad_t), 32'h1);
    step();
    step();
    chk("pre_idle_grant", 32'(grant), 32'h0);
    step();
    chk("pre_grant3", 32'(grant), 32'h8);
    // Non-owner drop is ignored; sole requester is never preempted.
    req = 4'b1000;
    for (int c = 0; c < 8; c++) step();
    chk("nopre_grant3", 32'(grant), 32'h8);
    chk("nopre_pad_t", 32'(pad_t), 32'h0);
    req = 4'b0000;
    step();
    step();
    step();
    chk("nopre_idle_busy", 32'(busy), 32'h0);

    // Round-robin with all requesting (ptr is 0); each owner keeps 3 cycles
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      do begin
        step();
        n++;
      end while (grant == 4'b0000 && n < 8);
      chk($sformatf("rr_grant_%0d", k), 32'(grant), 32'(rr_exp[k]));
      if (k > 0) chk($sformatf("rr_gap_%0d", k), 32'(n), 32'd3);
      step();
      step();
      req = 4'b1111 & ~rr_exp[k];
      step();
      chk($sformatf("rr_release_%0d", k), 32'(grant), 32'h0);
      req = 4'b1111;
    end
    req = 4'b0000;
    step();
    step();
    step();
    chk("rr_idle_busy", 32'(busy), 32'h0);

    // Readback while undriven
    chk("rd_ext0", 32'(rd_data), 32'h0);
    ext_drv = 1'b1;
    step();
    chk("rd_ext1", 32'(rd_data), 32'h1);
    ext_drv = 1'b0;

    // Async reset mid-ownership
    req = 4'b0010;
    step();
    step();
    chk("arst_pre_pad_t", 32'(pad_t), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pad_t", 32'(pad_t), 32'h1);
    chk("arst_grant", 32'(grant), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
